// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer turning 4-lane bit-reversed FFT beats into a natural-order bin stream.
module fft_out_reorder #(
  parameter int NBITS = 15,
  parameter int N     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBITS-1:0]     fftIn0_up,
  input  logic [NBITS-1:0]     fftIn0_down,
  input  logic [NBITS-1:0]     fftIn1_up,
  input  logic [NBITS-1:0]     fftIn1_down,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NBITS-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_index
);
  localparam int LB = $clog2(N);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} st_t;
  st_t                r_st [2];
  logic               r_wr, r_rd;
  logic [LB-3:0]      r_c;
  logic [LB-1:0]      r_k;
  logic [NBITS-1:0]   r_mem [2][N];
  logic [NBITS-1:0]   w_lane [4];
  logic               w_wr_en, w_rd_en, w_ord;

  function automatic logic [LB-1:0] bitrev(input logic [LB-1:0] x);
    for (int i = 0; i < LB; i++) bitrev[i] = x[LB-1-i];
  endfunction

  assign w_lane[0] = fftIn0_up;
  assign w_lane[1] = fftIn0_down;
  assign w_lane[2] = fftIn1_up;
  assign w_lane[3] = fftIn1_down;
  assign w_ord     = ~r_rd;
  assign in_ready  = (r_st[r_wr] == EMPTY) || (r_st[r_wr] == FILLING);
  assign out_valid = r_st[r_rd] == DRAINING;
  assign w_wr_en   = in_valid && in_ready;
  assign w_rd_en   = out_valid && out_ready;
  assign out_data  = out_valid ? r_mem[r_rd][r_k] : '0;
  assign out_index = r_k;
  assign out_last  = out_valid && (&r_k);

  // Lane l of beat c lands at bitrev(4c+l); the write bank is never the one being read.
  always_ff @(posedge clk)
    if (w_wr_en)
      for (int l = 0; l < 4; l++) r_mem[r_wr][bitrev({r_c, l[1:0]})] <= w_lane[l];

  // Write-side and read-side transitions touch disjoint banks, so both may fire in one cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_st[0] <= EMPTY;
      r_st[1] <= EMPTY;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_c     <= '0;
      r_k     <= '0;
    end else begin
      if (w_wr_en) begin
        r_c <= r_c + 1'b1;
        if (&r_c) begin
          r_st[r_wr] <= FULL;
          r_wr       <= ~r_wr;
        end else r_st[r_wr] <= FILLING;
      end
      if (r_st[r_rd] == FULL) r_st[r_rd] <= DRAINING;
      if (w_rd_en) begin
        r_k <= r_k + 1'b1;
        if (&r_k) begin
          r_st[r_rd] <= EMPTY;
          r_rd       <= w_ord;
          if (r_st[w_ord] == FULL) r_st[w_ord] <= DRAINING;
        end
      end
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed checks of the FFT output reorder buffer with N=32, NBITS=15.
module tb_fft_out_reorder;
  logic        clk = 0, rst = 0;
  logic [14:0] in0u = 0, in0d = 0, in1u = 0, in1d = 0;
  logic        in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, out_last;
  logic [14:0] out_data;
  logic [4:0]  out_index;

  int checks = 0, errors = 0;
  int q[$];
  int exp_k = 0, run = 0, last_run = 0;
  logic acc_in, hold_v = 0, rnd = 0;
  logic [14:0] hold_d;
  logic [4:0]  hold_i;

  fft_out_reorder #(.NBITS(15), .N(32)) dut (
    .clk(clk), .rst(rst),
    .fftIn0_up(in0u), .fftIn0_down(in0d), .fftIn1_up(in1u), .fftIn1_down(in1d),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_index(out_index)
  );

  always #5 clk = ~clk;

  function automatic int brev5(input int x);
    int r = 0;
    for (int i = 0; i < 5; i++) r[i] = x[4-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the handshake about to happen, then advance to the next falling edge.
  task automatic tick();
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    #1;
    acc_in = in_valid && in_ready;
    if (hold_v) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_d);
      chk("hold_index", out_index, hold_i);
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    hold_i = out_index;
    if (!out_valid) chk("last_idle", out_last, 0);
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_valid", out_valid, 0);
      else begin
        chk("data", out_data, q[0] * 32 + brev5(exp_k));
        chk("index", out_index, exp_k);
        chk("last", out_last, exp_k == 31);
        exp_k++;
        if (exp_k == 32) begin
          exp_k = 0;
          void'(q.pop_front());
        end
      end
    end
    if (out_valid) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_beat(input int tag, input int c);
    in0u = 15'(tag * 32 + 4 * c);
    in0d = 15'(tag * 32 + 4 * c + 1);
    in1u = 15'(tag * 32 + 4 * c + 2);
    in1d = 15'(tag * 32 + 4 * c + 3);
    in_valid = 1;
    for (int t = 0; t < 500; t++) begin
      tick();
      if (acc_in) break;
    end
    if (!acc_in) chk("in_timeout", acc_in, 1);
    in_valid = 0;
    if (c == 7) q.push_back(tag);
  endtask

  task automatic send_frame(input int tag);
    for (int c = 0; c < 8; c++) send_beat(tag, c);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && q.size() != 0; t++) tick();
    chk("drain_done", q.size(), 0);
  endtask

  task automatic pulse_reset();
    rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    in_valid = 0;
    #1 rst = 1;
    q.delete();
    exp_k = 0;
    hold_v = 0;
    run = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    chk("init_out_index", out_index, 0);
    chk("init_out_last", out_last, 0);
    chk("init_in_ready", in_ready, 1);
    rst = 1;
    @(negedge clk);
    // Ramp frame: lanes 4c..4c+3, so bin k must carry bitrev5(k).
    out_ready = 1;
    send_frame(0);
    chk("ramp_valid_before", out_valid, 0);
    tick();
    chk("ramp_valid_rise", out_valid, 1);
    chk("ramp_first_index", out_index, 0);
    drain();
    // Back-to-back frames must give one unbroken run of 64 valid cycles.
    send_frame(2);
    send_frame(3);
    drain();
    tick();
    chk("b2b_run", last_run, 64);
    // Consumer stalled while three frames are offered.
    out_ready = 0;
    send_frame(4);
    send_frame(5);
    chk("stall_in_ready", in_ready, 0);
    in0u = 15'(6 * 32); in0d = 15'(6 * 32 + 1); in1u = 15'(6 * 32 + 2); in1d = 15'(6 * 32 + 3);
    in_valid = 1;
    repeat (22) tick();
    chk("stall_in_ready_held", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_index", out_index, 0);
    out_ready = 1;
    send_frame(6);
    drain();
    // High-valued tags exercise the top data bit.
    send_frame(1000);
    drain();
    // Random backpressure and input gaps.
    rnd = 1;
    for (int f = 0; f < 100; f++)
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 2) == 0) tick();
        send_beat(100 + f, c);
      end
    drain();
    rnd = 0;
    out_ready = 1;
    tick();
    // Last beat of frame 21 lands on the same edge as bin 31 of frame 20.
    send_frame(20);
    repeat (25) tick();
    for (int c = 0; c < 8; c++) begin
      if (c == 7) chk("same_cycle_k", exp_k, 31);
      send_beat(21, c);
    end
    chk("same_cycle_in_ready", in_ready, 1);
    tick();
    chk("same_cycle_valid", out_valid, 1);
    chk("same_cycle_index", out_index, 0);
    drain();
    // Reset mid-fill at beat 4.
    for (int c = 0; c < 4; c++) send_beat(7, c);
    in0u = 15'(7 * 32 + 16);
    in_valid = 1;
    pulse_reset();
    send_frame(8);
    drain();
    // Reset mid-drain at bin 10.
    send_frame(9);
    for (int t = 0; t < 100 && exp_k != 10; t++) tick();
    chk("reach_bin10", exp_k, 10);
    chk("bin10_valid", out_valid, 1);
    pulse_reset();
    send_frame(10);
    drain();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter NBITS, default 15: width of one complex output word from the saturation stage.
REQ-002 SHALL have parameter N, default 32: FFT points per frame (power of 2, N >= 8).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, input, NBITS each: lanes 0..3 of one parallel FFT output beat.
REQ-006 SHALL have port in_valid, input, 1 bit: the four lanes carry a valid beat.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a beat this cycle.
REQ-008 SHALL have port out_data, output, NBITS: one bin in natural order.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_data.
REQ-011 SHALL have port out_last, output, 1 bit: out_data is bin N-1 of a frame.
REQ-012 SHALL have port out_index, output, log2(N) bits: bin number of out_data.

Function
REQ-013 A beat SHALL be accepted when in_valid & in_ready; one frame SHALL be N/4 accepted beats, indexed c = 0..N/4-1.
REQ-014 Lane l (0 = 0_up, 1 = 0_down, 2 = 1_up, 3 = 1_down) of beat c SHALL be stored as bin k = bitreverse_log2(N)(4c + l).
REQ-015 Storage SHALL be two banks (ping-pong) of N words; each bank has state EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
REQ-016 EMPTY -> FILLING SHALL occur on the first accepted beat into the write bank; FILLING -> FULL on the accepted beat c = N/4-1, after which the write pointer SHALL toggle.
REQ-017 in_ready SHALL be 1 iff the bank under the write pointer is EMPTY or FILLING.
REQ-018 FULL -> DRAINING SHALL occur when the bank is under the read pointer; out_valid SHALL be 1 iff the read bank is DRAINING.
REQ-019 Output latency: out_valid SHALL rise on the first clk edge after the edge that accepted the last beat of a frame, provided the read bank was free.
REQ-020 Bins SHALL be emitted k = 0,1,...,N-1; k SHALL advance only on out_valid & out_ready.
REQ-021 While out_valid & !out_ready, out_data, out_index and out_last SHALL hold stable.
REQ-022 out_last SHALL be 1 exactly when out_valid and out_index = N-1; on its acceptance the bank SHALL become EMPTY, the read pointer SHALL toggle and k SHALL wrap to 0.
REQ-023 If the other bank is FULL at that acceptance, out_valid SHALL remain 1 with no bubble and out_index = 0 of the next frame.
REQ-024 A frame-completing write and a frame-completing read in the same cycle SHALL both take effect, with no beat lost or duplicated.
REQ-025 in_valid while in_ready = 0 SHALL be ignored; the upstream holds the data.
REQ-026 Data SHALL pass bit-exact; no arithmetic, sign change or truncation.
REQ-027 Sustained throughput SHALL be 1 word/cycle out; input bursts of 4 words/cycle SHALL stall only when both banks are occupied.

Reset
REQ-028 rst = 0 SHALL asynchronously set both banks EMPTY, both pointers to bank 0, beat and bin counters to 0, out_valid = 0, out_last = 0, out_index = 0, out_data = 0, in_ready = 1.
REQ-029 Reset mid-frame SHALL discard partial and buffered frames; bank RAM contents need not be cleared.
REQ-030 After rst deasserts, the first accepted beat SHALL be treated as c = 0 of a new frame.

Verification
REQ-031 Ramp frame (N=32): beat c lanes = 4c..4c+3, out_ready = 1 -> out_data sequence equals bitreverse5(k) for k = 0..31, out_last on k = 31, out_valid 1 cycle after beat 7.
REQ-032 Back-to-back frames A then B, out_ready = 1 -> 64 contiguous valid outputs, no bubble between A bin 31 and B bin 0.
REQ-033 out_ready = 0 for 40 cycles while 3 frames are offered -> in_ready drops after beat 15, frame 3 is held, and all 3 frames are emitted intact once out_ready = 1.
REQ-034 Random out_ready and in_valid toggling over 100 frames -> scoreboard match, out_data stable whenever out_valid & !out_ready.
REQ-035 rst pulsed low at beat 4 of a frame and at bin 10 of a drain -> outputs go to their reset values immediately, and the next full frame is emitted correctly from bin 0.
REQ-036 Same-cycle write-complete and read-complete (one bank draining, one filling) -> pointers swap correctly and no word is lost or duplicated.
